// File: rtl/rv32i_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_fetch_pkg
// Description : Shared types and constants for the RV32I fetch front end.
// Revision    : 1.0 - initial release
// ============================================================================
package rv32i_fetch_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_RESET = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/rv32i_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_sync_fifo
// Description : Power-of-two synchronous FIFO with synchronous clear and occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
module rv32i_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             w_empty;
    logic             w_full;
    logic             w_do_pop;
    logic             w_do_push;

    assign w_empty   = (count_q == '0);
    assign w_full    = (count_q == CW'(DEPTH));
    assign w_do_pop  = i_pop && !w_empty;
    assign w_do_push = i_push && (!w_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (w_do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    // Storage needs no reset: occupancy alone decides what is readable.
    always_ff @(posedge clk) begin
        if (w_do_push) mem_q[wr_ptr_q] <= i_data;
    end

    assign o_data  = mem_q[rd_ptr_q];
    assign o_count = count_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(i_push && w_full && !i_pop && !i_clear));

endmodule
`default_nettype wire

// File: rtl/rv32i_ifetch.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_ifetch
// Description : RV32I instruction fetch front end: credit-limited request issue,
//               response buffering, redirect flush with in-flight drop.
// Revision    : 1.0 - initial release
// ============================================================================
module rv32i_ifetch
    import rv32i_fetch_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_redirect,
    input  logic [WIDTH-1:0] i_redirect_target,
    output logic             o_imem_req_valid,
    input  logic             i_imem_req_ready,
    output logic [WIDTH-1:0] o_imem_req_addr,
    input  logic             i_imem_rsp_valid,
    input  logic [WIDTH-1:0] i_imem_rsp_data,
    output logic             o_inst_valid,
    input  logic             i_inst_ready,
    output logic [WIDTH-1:0] o_inst,
    output logic [WIDTH-1:0] o_inst_pc,
    output logic [WIDTH-1:0] o_inst_pc_plus_4
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]    drop_cnt_q, drop_cnt_d;

    logic [CW-1:0]    w_outstanding;
    logic [CW-1:0]    w_buf_count;
    logic [CW:0]      w_credit_used;
    logic             w_req_valid;
    logic             w_req_fire;
    logic             w_rsp;
    logic             w_discard;
    logic             w_buf_push;
    logic             w_buf_pop;
    logic             w_buf_valid;
    logic [WIDTH-1:0] w_pcq_head;
    fetch_entry_t     w_push_entry;
    fetch_entry_t     w_head;

    // Credits cover both in-flight requests and buffered instructions, so the
    // buffer can always absorb every response without backpressure.
    assign w_credit_used = {1'b0, w_outstanding} + {1'b0, w_buf_count};
    assign w_req_valid   = !rst && !i_redirect && (w_credit_used < (CW+1)'(FIFO_DEPTH));
    assign w_req_fire    = w_req_valid && i_imem_req_ready;

    assign w_rsp         = i_imem_rsp_valid && !rst;
    assign w_discard     = i_redirect || (drop_cnt_q != '0);
    assign w_buf_push    = w_rsp && !w_discard;

    assign w_buf_valid   = (w_buf_count != '0) && !rst;
    assign w_buf_pop     = o_inst_valid && i_inst_ready;

    assign w_push_entry.pc   = w_pcq_head;
    assign w_push_entry.inst = i_imem_rsp_data;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        drop_cnt_d = drop_cnt_q;
        if (w_req_fire) begin
            fetch_pc_d = fetch_pc_q + WIDTH'(4);
        end
        if (w_rsp && (drop_cnt_q != '0)) begin
            drop_cnt_d = drop_cnt_q - CW'(1);
        end
        // Everything still in flight after this cycle's response belongs to
        // the abandoned path; reload rather than accumulate.
        if (i_redirect) begin
            fetch_pc_d = i_redirect_target & ~WIDTH'(3);
            drop_cnt_d = w_outstanding - CW'(w_rsp);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= PC_RESET;
            drop_cnt_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    rv32i_sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_pc_queue (
        .clk     (clk),
        .rst     (rst),
        .i_clear (1'b0),
        .i_push  (w_req_fire),
        .i_data  (fetch_pc_q),
        .i_pop   (w_rsp),
        .o_data  (w_pcq_head),
        .o_count (w_outstanding)
    );

    rv32i_sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_inst_buf (
        .clk     (clk),
        .rst     (rst),
        .i_clear (i_redirect),
        .i_push  (w_buf_push),
        .i_data  (w_push_entry),
        .i_pop   (w_buf_pop),
        .o_data  (w_head),
        .o_count (w_buf_count)
    );

    assign o_imem_req_valid = w_req_valid;
    assign o_imem_req_addr  = rst ? '0 : fetch_pc_q;
    assign o_inst_valid     = w_buf_valid && !i_redirect;
    assign o_inst           = w_buf_valid ? w_head.inst : '0;
    assign o_inst_pc        = w_buf_valid ? w_head.pc : '0;
    assign o_inst_pc_plus_4 = w_buf_valid ? (w_head.pc + WIDTH'(4)) : '0;

    a_rsp_has_request: assert property (@(posedge clk) disable iff (rst)
        i_imem_rsp_valid |-> (w_outstanding != '0));

    a_drop_bounded: assert property (@(posedge clk) disable iff (rst)
        drop_cnt_q <= w_outstanding);

endmodule
`default_nettype wire

// File: tb/tb_rv32i_ifetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv32i_ifetch
// Description : Self-checking bench for rv32i_ifetch with a queue-level fetch model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv32i_ifetch;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_redirect = 1'b0;
    logic [31:0] i_redirect_target = '0;
    logic        o_imem_req_valid;
    logic        i_imem_req_ready = 1'b1;
    logic [31:0] o_imem_req_addr;
    logic        i_imem_rsp_valid = 1'b0;
    logic [31:0] i_imem_rsp_data = '0;
    logic        o_inst_valid;
    logic        i_inst_ready = 1'b1;
    logic [31:0] o_inst;
    logic [31:0] o_inst_pc;
    logic [31:0] o_inst_pc_plus_4;

    rv32i_ifetch #(.WIDTH(32), .FIFO_DEPTH(D)) dut (
        .clk               (clk),
        .rst               (rst),
        .i_redirect        (i_redirect),
        .i_redirect_target (i_redirect_target),
        .o_imem_req_valid  (o_imem_req_valid),
        .i_imem_req_ready  (i_imem_req_ready),
        .o_imem_req_addr   (o_imem_req_addr),
        .i_imem_rsp_valid  (i_imem_rsp_valid),
        .i_imem_rsp_data   (i_imem_rsp_data),
        .o_inst_valid      (o_inst_valid),
        .i_inst_ready      (i_inst_ready),
        .o_inst            (o_inst),
        .o_inst_pc         (o_inst_pc),
        .o_inst_pc_plus_4  (o_inst_pc_plus_4)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; bit stale; }             infl_t;
    typedef struct { logic [31:0] pc; logic [31:0] inst; }     ent_t;
    typedef struct { int due; logic [31:0] addr; }             memreq_t;
    typedef struct { logic [31:0] pc; logic [31:0] p4; logic [31:0] inst; int cyc; } dlv_t;

    infl_t       infl[$];
    ent_t        mbuf[$];
    memreq_t     mq[$];
    dlv_t        dlog[$];
    logic [31:0] m_fetch = '0;
    int          cyc = 0;
    int          latency = 1;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          req_fires = 0;

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return (a ^ 32'h5A5A_0000) + 32'h13;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs, compare against the model, advance the model.
    task automatic tick(bit r, bit redir, logic [31:0] tgt, bit dready);
        bit          rsp;
        logic [31:0] rdata;
        bit          e_req_v;
        bit          e_inst_v;
        infl_t       head;
        rsp   = 1'b0;
        rdata = '0;
        if (!r && mq.size() > 0 && mq[0].due == cyc) begin
            rsp   = 1'b1;
            rdata = mem_word(mq[0].addr);
            void'(mq.pop_front());
        end
        rst               = r;
        i_redirect        = redir;
        i_redirect_target = tgt;
        i_inst_ready      = dready;
        i_imem_rsp_valid  = rsp;
        i_imem_rsp_data   = rdata;
        #1;
        e_req_v  = !r && !redir && (infl.size() + mbuf.size() < D);
        e_inst_v = !r && !redir && (mbuf.size() > 0);
        chk("req_valid", 32'(o_imem_req_valid), 32'(e_req_v));
        chk("inst_valid", 32'(o_inst_valid), 32'(e_inst_v));
        if (r) begin
            chk("rst_req_addr", o_imem_req_addr, 32'h0);
            chk("rst_inst", o_inst, 32'h0);
            chk("rst_inst_pc", o_inst_pc, 32'h0);
            chk("rst_pc_plus_4", o_inst_pc_plus_4, 32'h0);
        end else begin
            if (e_req_v) chk("req_addr", o_imem_req_addr, m_fetch);
            if (e_inst_v) begin
                chk("inst", o_inst, mbuf[0].inst);
                chk("inst_pc", o_inst_pc, mbuf[0].pc);
                chk("pc_plus_4", o_inst_pc_plus_4, mbuf[0].pc + 32'd4);
            end
        end
        if (o_inst_valid && dready)
            dlog.push_back('{pc: o_inst_pc, p4: o_inst_pc_plus_4, inst: o_inst, cyc: cyc});
        if (o_imem_req_valid && i_imem_req_ready) req_fires++;
        if (r) begin
            infl.delete();
            mbuf.delete();
            mq.delete();
            m_fetch = '0;
        end else begin
            if (e_inst_v && dready) void'(mbuf.pop_front());
            if (rsp && infl.size() > 0) begin
                head = infl.pop_front();
                if (!head.stale && !redir) mbuf.push_back('{pc: head.pc, inst: rdata});
            end
            if (e_req_v && i_imem_req_ready) begin
                infl.push_back('{pc: m_fetch, stale: 1'b0});
                mq.push_back('{due: cyc + latency, addr: m_fetch});
                m_fetch = m_fetch + 32'd4;
            end
            if (redir) begin
                mbuf.delete();
                foreach (infl[i]) infl[i].stale = 1'b1;
                m_fetch = {tgt[31:2], 2'b00};
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        int t0;
        int n;
        int stale_n;
        @(posedge clk);
        #1;

        // Reset, 1-cycle memory, decode always ready
        latency = 1;
        tick(1, 0, 0, 1);
        tick(1, 0, 0, 1);
        dlog.delete();
        t0 = cyc;
        repeat (8) tick(0, 0, 0, 1);
        chk("t1_delivered", 32'(dlog.size()), 32'd6);
        if (dlog.size() >= 6) begin
            chk("t1_first_pc", dlog[0].pc, 32'h0);
            chk("t1_first_p4", dlog[0].p4, 32'h4);
            chk("t1_first_cyc", 32'(dlog[0].cyc - t0), 32'd2);
            chk("t1_first_inst", dlog[0].inst, 32'h5A5A_0013);
            chk("t1_pc5", dlog[5].pc, 32'h14);
            chk("t1_p4_5", dlog[5].p4, 32'h18);
        end

        // Decode stalled, 3-cycle memory: credit limit stops issue at 4
        latency = 3;
        tick(1, 0, 0, 0);
        dlog.delete();
        req_fires = 0;
        repeat (10) tick(0, 0, 0, 0);
        chk("t2_req_count", 32'(req_fires), 32'd4);
        chk("t2_req_valid_low", 32'(o_imem_req_valid), 32'd0);
        chk("t2_none_delivered", 32'(dlog.size()), 32'd0);
        repeat (10) tick(0, 0, 0, 1);
        chk("t2_enough", 32'(dlog.size() >= 4), 32'd1);
        if (dlog.size() >= 4)
            for (int i = 0; i < 4; i++) chk("t2_order_pc", dlog[i].pc, 32'(i * 4));

        // Redirect with two requests in flight
        tick(1, 0, 0, 1);
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 1);
        dlog.delete();
        t0 = cyc;
        tick(0, 1, 32'h100, 1);
        repeat (10) tick(0, 0, 0, 1);
        stale_n = 0;
        foreach (dlog[i]) if (dlog[i].pc < 32'h100) stale_n++;
        chk("t3_no_stale", 32'(stale_n), 32'd0);
        chk("t3_got_some", 32'(dlog.size() > 0), 32'd1);
        if (dlog.size() > 0) begin
            chk("t3_first_pc", dlog[0].pc, 32'h100);
            chk("t3_redirect_to_valid", 32'(dlog[0].cyc - t0), 32'd5);
        end

        // Misaligned redirect target
        dlog.delete();
        tick(0, 1, 32'h203, 1);
        i_redirect = 1'b0;
        #1;
        chk("t4_req_valid", 32'(o_imem_req_valid), 32'd1);
        chk("t4_req_addr", o_imem_req_addr, 32'h200);
        repeat (8) tick(0, 0, 0, 1);
        chk("t4_got_some", 32'(dlog.size() > 0), 32'd1);
        if (dlog.size() > 0) chk("t4_first_pc", dlog[0].pc, 32'h200);

        // Redirect in the same cycle decode would consume
        repeat (3) tick(0, 0, 0, 0);
        i_inst_ready = 1'b0;
        #1;
        chk("t5_buf_nonempty", 32'(o_inst_valid), 32'd1);
        n = dlog.size();
        tick(0, 1, 32'h400, 1);
        chk("t5_no_consume", 32'(dlog.size()), 32'(n));
        i_redirect = 1'b0;
        #1;
        chk("t5_empty_next", 32'(o_inst_valid), 32'd0);
        repeat (10) tick(0, 0, 0, 1);
        chk("t5_got_some", 32'(dlog.size() > n), 32'd1);
        if (dlog.size() > n) chk("t5_first_pc", dlog[n].pc, 32'h400);

        // Address wrap at the top of memory
        latency = 1;
        tick(1, 0, 0, 1);
        dlog.delete();
        tick(0, 1, 32'hFFFF_FFF8, 1);
        repeat (8) tick(0, 0, 0, 1);
        chk("t6_enough", 32'(dlog.size() >= 3), 32'd1);
        if (dlog.size() >= 3) begin
            chk("t6_pc0", dlog[0].pc, 32'hFFFF_FFF8);
            chk("t6_p4_0", dlog[0].p4, 32'hFFFF_FFFC);
            chk("t6_pc1", dlog[1].pc, 32'hFFFF_FFFC);
            chk("t6_p4_1", dlog[1].p4, 32'h0);
            chk("t6_pc2", dlog[2].pc, 32'h0);
        end

        // Reset mid-stream with requests outstanding
        latency = 3;
        repeat (6) tick(0, 0, 0, 1);
        tick(1, 0, 0, 1);
        rst = 1'b0;
        i_redirect = 1'b0;
        i_imem_rsp_valid = 1'b0;
        #1;
        chk("t7_inst_valid", 32'(o_inst_valid), 32'd0);
        chk("t7_req_addr", o_imem_req_addr, 32'h0);
        chk("t7_inst", o_inst, 32'h0);
        chk("t7_inst_pc", o_inst_pc, 32'h0);
        chk("t7_pc_plus_4", o_inst_pc_plus_4, 32'h0);
        dlog.delete();
        t0 = cyc;
        repeat (8) tick(0, 0, 0, 1);
        chk("t7_got_some", 32'(dlog.size() > 0), 32'd1);
        if (dlog.size() > 0) begin
            chk("t7_first_pc", dlog[0].pc, 32'h0);
            chk("t7_first_cyc", 32'(dlog[0].cyc - t0), 32'd4);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
